mul_div_unit: RTL and testbench

//  Iterative multiply/divide unit for the pipelined MIPS core; sits beside the execute stage and owns HI/LO.

---
 rtl/mdu_pkg.sv | 23 ++
 rtl/adderc.sv | 17 +
 rtl/mul_div_unit.sv | 187 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_pkg;

  // Default operand width; HI and LO are this wide, one iteration per bit.
  localparam int MDU_WIDTH = 32;
  localparam int CNT_W     = $clog2(MDU_WIDTH);

  // Operation encodings as seen on the op input.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  // Controller states.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/adderc.sv
// Plain ripple-style adder with carry in and carry out.
module adderc #(
  parameter int N = 33
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  // Sum of a, b and carry-in with the carry-out kept as the top bit.
  always_comb begin
    {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, one result bit per cycle.
//
// Handshake: start is accepted only in a cycle where busy is low; op, a and b
// are sampled on that same edge. busy stays high until the cycle in which done
// pulses. While busy, start/mthi/mtlo are ignored. mthi/mtlo write wdata into
// HI/LO on any idle edge where start is not also asserted.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       state_o
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e       state_q;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  // acc_hi/acc_lo: partial product, or remainder/quotient while dividing.
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q;
  // opnd: multiplicand magnitude, or divisor magnitude.
  logic [WIDTH-1:0] opnd_q;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q, neg_lo_q, neg_hi_q, dz_wait_q;

  // Operand magnitudes and sign bookkeeping at load time.
  logic             signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & a[WIDTH-1];
    b_neg     = signed_op & b[WIDTH-1];
    a_mag     = a_neg ? (~a + 1'b1) : a;
    b_mag     = b_neg ? (~b + 1'b1) : b;
  end

  // Shared adder: add for multiply, a + ~b + 1 for the divide trial subtract.
  logic [WIDTH:0] add_a, add_b, add_sum, mul_wide;
  logic           add_cin, add_cout;

  adderc #(.N(WIDTH + 1)) u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // One iteration of shift-add multiply or restoring divide.
  logic [WIDTH-1:0] acc_hi_d, acc_lo_d;

  always_comb begin
    add_a    = {1'b0, acc_hi_q};
    add_b    = {1'b0, opnd_q};
    add_cin  = 1'b0;
    mul_wide = {1'b0, acc_hi_q};
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    if (is_div_q) begin
      // Shift {rem,quo} left; the bit leaving quo becomes rem's new LSB.
      add_a   = {acc_hi_q, acc_lo_q[WIDTH-1]};
      add_b   = ~{1'b0, opnd_q};
      add_cin = 1'b1;
      if (add_cout) begin
        acc_hi_d = add_sum[WIDTH-1:0];
        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi_d = add_a[WIDTH-1:0];
        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Carry of the add is kept and shifted down into acc_hi's MSB.
      mul_wide = acc_lo_q[0] ? add_sum : {1'b0, acc_hi_q};
      acc_hi_d = mul_wide[WIDTH:1];
      acc_lo_d = {mul_wide[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  // Sign correction applied when the loop finishes.
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   hi_fix, lo_fix;

  always_comb begin
    prod_neg = ~{acc_hi_q, acc_lo_q} + 1'b1;
    hi_fix   = acc_hi_q;
    lo_fix   = acc_lo_q;
    if (is_div_q) begin
      if (neg_lo_q) lo_fix = ~acc_lo_q + 1'b1;
      if (neg_hi_q) hi_fix = ~acc_hi_q + 1'b1;
    end else if (neg_lo_q) begin
      hi_fix = prod_neg[2*WIDTH-1:WIDTH];
      lo_fix = prod_neg[WIDTH-1:0];
    end
  end

  // Controller and all architectural/working registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      dz_wait_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q   <= 1'b1;
            is_div_q <= op[1];
            cnt_q    <= '0;
            if (op[1] && (b == '0)) begin
              // Divide by zero: forced result, one extra FIX cycle keeps latency at two.
              acc_hi_q  <= a;
              acc_lo_q  <= '1;
              neg_lo_q  <= 1'b0;
              neg_hi_q  <= 1'b0;
              dz_wait_q <= 1'b1;
              state_q   <= S_FIX;
            end else begin
              acc_hi_q <= '0;
              acc_lo_q <= op[1] ? a_mag : b_mag;
              opnd_q   <= op[1] ? b_mag : a_mag;
              neg_lo_q <= a_neg ^ b_neg;
              neg_hi_q <= op[1] & a_neg;
              state_q  <= S_RUN;
            end
          end else begin
            if (mthi) hi_q <= wdata;
            if (mtlo) lo_q <= wdata;
          end
        end
        S_RUN: begin
          acc_hi_q <= acc_hi_d;
          acc_lo_q <= acc_lo_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
        end
        S_FIX: begin
          if (dz_wait_q) begin
            dz_wait_q <= 1'b0;
          end else begin
            hi_q    <= hi_fix;
            lo_q    <= lo_fix;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit with a plain-arithmetic reference model.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        mthi = 1'b0, mtlo = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [1:0]  state_o;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi = '0, model_lo = '0;

  mul_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .state_o(state_o)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  // Reference: MIPS semantics via 64-bit arithmetic; result packed as {hi,lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = '0;
    case (o)
      OP_MULT:  res = 64'(sx * sy);
      OP_MULTU: res = {32'b0, x} * {32'b0, y};
      OP_DIV: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {32'(r), 32'(q)};
        end
      end
      default: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else res = {x % y, x / y};
      end
    endcase
    return res;
  endfunction

  function automatic logic [31:0] pick_operand(input bit allow_zero);
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return allow_zero ? 32'h0 : 32'h1;
      3: return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Driver: issue one op, optionally disturb it mid-run, check latency/busy/result.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp, input int lat,
                        input int disturb_at);
    int n, busy_n;
    bit seen;
    logic [63:0] want;
    exp_q.push_back(exp);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    checks++;
    if (busy !== 1'b1 || done !== 1'b0)
      begin errors++; $display("FAIL %s accept: busy=%b done=%b required busy=1 done=0", name, busy, done); end
    busy_n = 1; n = 0; seen = 0;
    while (!seen && n < 60) begin
      if (n == disturb_at) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = $urandom; b = 32'h3;
      end
      @(posedge clk); #1;
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      n++;
      if (done === 1'b1) seen = 1;
      else if (busy === 1'b1) busy_n++;
    end
    want = exp_q.pop_front();
    checks++;
    if (n != lat)
      begin errors++; $display("FAIL %s latency: got %0d cycles required %0d", name, n, lat); end
    checks++;
    if (busy_n != lat || busy !== 1'b0)
      begin errors++; $display("FAIL %s busy: high %0d cycles busy_now=%b required %0d and 0", name, busy_n, busy, lat); end
    checks++;
    if ({hi, lo} !== want)
      begin errors++; $display("FAIL %s result: hi=%h lo=%h required hi=%h lo=%h", name, hi, lo, want[63:32], want[31:0]); end
    model_hi = want[63:32];
    model_lo = want[31:0];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
      begin errors++; $display("FAIL reset: busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo); end
    reset = 1'b0;
    model_hi = '0; model_lo = '0;
  endtask

  task automatic test_directed();
    run_op("multu_ff", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, -1);
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: done=%b required 0", done); end
    run_op("mult_m3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 33, -1);
    run_op("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, -1);
    run_op("divu_100d7", OP_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 33, -1);
    run_op("divu_by0", OP_DIVU, 32'h1234, 32'h0, 64'h0000_1234_FFFF_FFFF, 2, -1);
    run_op("div_by0", OP_DIV, 32'h8765_4321, 32'h0, 64'h8765_4321_FFFF_FFFF, 2, -1);
    run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33, -1);
    run_op("mult_min_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33, -1);
    run_op("div_7dm2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33, -1);
  endtask

  task automatic test_mt();
    mthi = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    mthi = 1'b0;
    checks++;
    if (hi !== 32'hA5A5_A5A5 || lo !== model_lo || done !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL mthi: hi=%h lo=%h required hi=a5a5a5a5 lo=%h", hi, lo, model_lo); end
    model_hi = 32'hA5A5_A5A5;
    mtlo = 1'b1; wdata = 32'h5A5A_0F0F;
    @(posedge clk); #1;
    mtlo = 1'b0;
    checks++;
    if (hi !== model_hi || lo !== 32'h5A5A_0F0F)
      begin errors++; $display("FAIL mtlo: hi=%h lo=%h required hi=%h lo=5a5a0f0f", hi, lo, model_hi); end
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    checks++;
    if (hi !== 32'h1357_9BDF || lo !== 32'h1357_9BDF)
      begin errors++; $display("FAIL mt_both: hi=%h lo=%h required 13579bdf twice", hi, lo); end
    // start wins over a simultaneous mthi
    mthi = 1'b1; wdata = 32'hDEAD_BEEF;
    run_op("start_over_mthi", OP_MULTU, 32'd3, 32'd5, model(OP_MULTU, 32'd3, 32'd5), 33, -1);
  endtask

  task automatic test_busy_ignore();
    run_op("busy_disturb", OP_MULTU, 32'h0001_0001, 32'h0000_FFFF,
           model(OP_MULTU, 32'h0001_0001, 32'h0000_FFFF), 33, 5);
    run_op("busy_disturb_div", OP_DIV, 32'hFFFF_F000, 32'd9,
           model(OP_DIV, 32'hFFFF_F000, 32'd9), 33, 20);
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      x = pick_operand(1'b1);
      y = pick_operand(1'b1);
      run_op($sformatf("rand%0d_op%0d", i, o), o, x, y, model(o, x, y),
             (o[1] && y == 0) ? 2 : 33, -1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] x, y;
    for (int i = 0; i < 4; i++) begin
      x = $urandom; y = 32'($urandom_range(1, 1000));
      run_op($sformatf("b2b%0d", i), 2'(i), x, y, model(2'(i), x, y), 33, -1);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; op = OP_MULTU; a = 32'hFFFF_0000; b = 32'h0000_FFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
      begin errors++; $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h required 0 0 0 0", busy, done, hi, lo); end
    run_op("after_reset_6x7", OP_MULTU, 32'd6, 32'd7, 64'd42, 33, -1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mt();
    test_busy_ignore();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
